// File: rtl/adc_display_pkg.sv
// Shared types and constants for the ADC voltage display: converter states,
// active-low seven-segment patterns and the BCD saturation limit.
package adc_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam logic [15:0] BCD_MAX = 16'd9999;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    if (digit <= 4'd9) return SEG_LUT[digit];
    return 7'h7F;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter with a one-deep newest-wins request buffer.
// A conversion takes 16 cycles from load to the next possible load.
module bin2bcd_serial
  import adc_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_busy,
  output logic [15:0] o_bcd,
  output logic [15:0] o_bcd_next,
  output logic        o_bcd_valid,
  output logic        o_overflow
);

  conv_state_t r_state, w_state_next;
  logic [13:0] r_bin;
  logic [15:0] r_scratch;
  logic [15:0] w_adj;
  logic [3:0]  r_cnt;
  logic        r_ovf_next;
  logic        r_pend_valid;
  logic [15:0] r_pend_data;
  logic [15:0] r_bcd;
  logic        r_bcd_valid;
  logic        r_overflow;
  logic        w_load;
  logic [15:0] w_load_data;

  // A fresh strobe in IDLE supersedes anything still pending.
  assign w_load      = (r_state == IDLE) && (i_valid || r_pend_valid);
  assign w_load_data = i_valid ? i_data : r_pend_data;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == 4'd13) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bin       <= '0;
      r_scratch   <= '0;
      r_cnt       <= '0;
      r_ovf_next  <= 1'b0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_load) begin
          r_bin      <= (w_load_data > BCD_MAX) ? BCD_MAX[13:0] : w_load_data[13:0];
          r_scratch  <= '0;
          r_ovf_next <= (w_load_data > BCD_MAX);
          r_cnt      <= '0;
        end
        SHIFT: begin
          {r_scratch, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
          r_cnt              <= r_cnt + 4'd1;
        end
        DONE: begin
          r_bcd       <= r_scratch;
          r_overflow  <= r_ovf_next;
          r_bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
    end else if (r_state == IDLE) begin
      if (w_load) r_pend_valid <= 1'b0;
    end else if (i_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_data  <= i_data;
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_bcd       = r_bcd;
  // Lets the scan pick up a result on the same edge it is published.
  assign o_bcd_next  = (r_state == DONE) ? r_scratch : r_bcd;
  assign o_bcd_valid = r_bcd_valid;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/adc_voltage_display.sv
// Millivolt-to-display top: BCD conversion plus a 4-digit common-anode scan
// showing V.VVV, with digit index 3 (leftmost) carrying the decimal point.
module adc_voltage_display
  import adc_display_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 100_000_000,
  parameter int unsigned REFRESH_FREQ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        busy,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        overflow,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned TICK_DIV = CLOCK_FREQ / REFRESH_FREQ;
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [15:0]   w_bcd_next;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;

  bin2bcd_serial u_conv (
    .clk         (clk),
    .reset       (reset),
    .i_data      (data_in),
    .i_valid     (data_valid),
    .o_busy      (busy),
    .o_bcd       (bcd_out),
    .o_bcd_next  (w_bcd_next),
    .o_bcd_valid (bcd_valid),
    .o_overflow  (overflow)
  );

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx <= 2'd0;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_an  <= 4'hF;
    end else if (w_tick) begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= seg_decode(w_bcd_next[{r_idx, 2'b00} +: 4]);
      r_dp  <= (r_idx != 2'd3);
      r_idx <= r_idx + 2'd1;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_adc_voltage_display.sv
// Randomized self-checking bench for adc_voltage_display against a decimal
// arithmetic model of the conversion, scan order and segment patterns.
module tb_adc_voltage_display;

  localparam int unsigned CLK_HZ = 4000;
  localparam int unsigned REF_HZ = 1000;
  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        busy;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        overflow;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [15:0] v;
    logic        o;
  } ev_t;
  ev_t evq[$];

  adc_voltage_display #(
    .CLOCK_FREQ   (CLK_HZ),
    .REFRESH_FREQ (REF_HZ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .busy       (busy),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .overflow   (overflow),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bcd_valid) evq.push_back('{cyc, bcd_out, overflow});
  end

  function automatic int clampv(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int digit_of(input int v, input int pos);
    int p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    return (clampv(v) / p) % 10;
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = r | (16'(digit_of(v, i)) << (4 * i));
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Drive one strobe; called #1 after an edge, returns the sampling edge number.
  task automatic pulse(input int v, output int n);
    data_in = 16'(v);
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    data_valid = 1'b0;
  endtask

  task automatic convert_check(input int v);
    int n, k;
    pulse(v, n);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_load v=%0d: got %b want 1", v, busy);
    end
    k = 0;
    while (bcd_valid !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (bcd_valid !== 1'b1) begin
      errors++;
      $display("FAIL bcd_valid_timeout v=%0d: got none within 40 cycles want one", v);
      return;
    end
    if (cyc - n != 15) begin
      errors++;
      $display("FAIL latency v=%0d: got %0d want 15", v, cyc - n);
    end
    checks++;
    if (bcd_out !== ref_bcd(v)) begin
      errors++;
      $display("FAIL bcd_out v=%0d: got %h want %h", v, bcd_out, ref_bcd(v));
    end
    checks++;
    if (overflow !== (v > 9999)) begin
      errors++;
      $display("FAIL overflow v=%0d: got %b want %b", v, overflow, (v > 9999));
    end
    @(posedge clk);
    #1;
    checks++;
    if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_one_cycle v=%0d: got valid=%b busy=%b want 0 0", v, bcd_valid, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || bcd_out !== 16'h0000 || bcd_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_conv: got busy=%b bcd=%h valid=%b ovf=%b want 0 0000 0 0",
               tag, busy, bcd_out, bcd_valid, overflow);
    end
    checks++;
    if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF) begin
      errors++;
      $display("FAIL %s_disp: got seg=%h dp=%b an=%b want 7f 1 1111", tag, seg, dp, an);
    end
  endtask

  task automatic wait_an_change(output bit ok);
    logic [3:0] old;
    int k;
    old = an;
    k = 0;
    while (an === old && k < 3 * TICK) begin
      @(posedge clk);
      #1;
      k++;
    end
    ok = (an !== old);
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b0;
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      errors++;
      $display("FAIL blank_before_tick: got an=%b seg=%h want 1111 7f", an, seg);
    end
    wait_an_change(ok);
    checks++;
    if (!ok || an !== 4'b1110 || seg !== ref_seg(0) || dp !== 1'b1) begin
      errors++;
      $display("FAIL first_tick: got an=%b seg=%h dp=%b want 1110 %h 1", an, seg, dp, ref_seg(0));
    end
  endtask

  task automatic test_scan(input int v);
    bit ok;
    int idx, prev_idx, last_c;
    convert_check(v);
    wait_an_change(ok);
    prev_idx = -1;
    last_c = cyc;
    for (int step = 0; step < 8; step++) begin
      wait_an_change(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL scan_stall v=%0d: got an stuck at %b want a change", v, an);
        return;
      end
      idx = -1;
      for (int b = 0; b < 4; b++) if (an[b] === 1'b0) idx = b;
      if ($countones(~an) != 1 || idx < 0) begin
        errors++;
        $display("FAIL scan_onehot v=%0d: got an=%b want exactly one low", v, an);
        continue;
      end
      checks++;
      if (seg !== ref_seg(digit_of(v, idx)) || dp !== (idx != 3)) begin
        errors++;
        $display("FAIL scan_digit v=%0d idx=%0d: got seg=%h dp=%b want %h %b",
                 v, idx, seg, dp, ref_seg(digit_of(v, idx)), (idx != 3));
      end
      if (prev_idx >= 0) begin
        checks++;
        if (idx != (prev_idx + 1) % 4 || cyc - last_c != TICK) begin
          errors++;
          $display("FAIL scan_order v=%0d: got idx=%0d after %0d cycles want idx=%0d after %0d",
                   v, idx, cyc - last_c, (prev_idx + 1) % 4, TICK);
        end
      end
      prev_idx = idx;
      last_c = cyc;
    end
  endtask

  task automatic test_boundaries();
    convert_check(9999);
    convert_check(12000);
    convert_check(3300);
    convert_check(10000);
    convert_check(65535);
  endtask

  task automatic test_random();
    int v;
    repeat (16) begin
      v = int'($urandom_range(0, 20000));
      convert_check(v);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    evq.delete();
    pulse(100, n);
    @(posedge clk);
    #1;
    data_in = 16'd200;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    data_in = 16'd300;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (evq.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 2", evq.size());
    end
    if (evq.size() >= 1) begin
      checks++;
      if (evq[0].c != n + 15 || evq[0].v !== ref_bcd(100)) begin
        errors++;
        $display("FAIL b2b_first: got %h at +%0d want %h at +15", evq[0].v, evq[0].c - n, ref_bcd(100));
      end
    end
    if (evq.size() >= 2) begin
      checks++;
      if (evq[1].c != n + 31 || evq[1].v !== ref_bcd(300)) begin
        errors++;
        $display("FAIL b2b_second: got %h at +%0d want %h at +31", evq[1].v, evq[1].c - n, ref_bcd(300));
      end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    evq.delete();
    pulse(2500, n);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (evq.size() != 0 || bcd_out !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_publish: got %0d results bcd=%h busy=%b want 0 0000 0",
               evq.size(), bcd_out, busy);
    end
    convert_check(42);
  endtask

  initial begin
    test_reset();
    test_scan(1650);
    test_boundaries();
    test_scan(0);
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_scan(2718);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
